// File: rtl/menu_pkg.sv
// Shared definitions for the song-selection menu and its overlay renderer.
// Contents: menu state encoding, state width, maximum supported song count.
package menu_pkg;

  localparam int unsigned MENU_STATE_W = 2;
  localparam int unsigned MAX_SONGS    = 16;

  typedef enum logic [MENU_STATE_W-1:0] {
    MENU   = 2'd0,
    START  = 2'd1,
    PLAY   = 2'd2,
    RESULT = 2'd3
  } menu_state_e;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced button level.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   level       - debounced button level
//   rise_c      - combinational one-cycle event: level & ~prev
// A button held through reset release is masked until it has been released.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise_c
);

  logic prev_q;
  logic block_q;

  // Previous-level register plus hold-through-reset mask
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q  <= 1'b0;
      block_q <= level;
    end else begin
      prev_q <= level;
      if (!level) begin
        block_q <= 1'b0;
      end
    end
  end

  assign rise_c = level & ~prev_q & ~block_q;

endmodule

// File: rtl/song_menu_fsm.sv
// Song-selection menu controller: scrolls a cursor over NUM_SONGS entries,
// latches the selection on enter, pulses game_reset, then holds in PLAY
// until done or back, and shows RESULT until enter is pressed.
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   up, down, enter, back - debounced button levels (rising edge = event)
//   done                  - scorer level, song finished
//   menu_state            - encoded FSM state (menu_pkg::menu_state_e)
//   cursor                - highlighted entry
//   song_sel              - entry latched on the MENU enter event
//   game_reset            - one-cycle pulse while in START
//   in_game               - high while in PLAY
// Build option: define SONG_MENU_WRAP_EN to make the cursor wrap at both ends;
// otherwise it saturates at 0 and NUM_SONGS-1.
module song_menu_fsm
  import menu_pkg::*;
#(
  parameter  int unsigned NUM_SONGS = 4,
  localparam int unsigned SONG_W    = $clog2(NUM_SONGS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    up,
  input  logic                    down,
  input  logic                    enter,
  input  logic                    back,
  input  logic                    done,
  output logic [MENU_STATE_W-1:0] menu_state,
  output logic [SONG_W-1:0]       cursor,
  output logic [SONG_W-1:0]       song_sel,
  output logic                    game_reset,
  output logic                    in_game
);

  localparam logic [SONG_W-1:0] FIRST_SONG = '0;
  localparam logic [SONG_W-1:0] LAST_SONG  = SONG_W'(NUM_SONGS - 1);

  if (NUM_SONGS < 2 || NUM_SONGS > MAX_SONGS) begin : g_bad_num_songs
    $error("song_menu_fsm: NUM_SONGS out of range 2..16");
  end

  logic up_ev_c, down_ev_c, enter_ev_c, back_ev_c;

  btn_edge u_up_edge    (.clk(clk), .reset(reset), .level(up),    .rise_c(up_ev_c));
  btn_edge u_down_edge  (.clk(clk), .reset(reset), .level(down),  .rise_c(down_ev_c));
  btn_edge u_enter_edge (.clk(clk), .reset(reset), .level(enter), .rise_c(enter_ev_c));
  btn_edge u_back_edge  (.clk(clk), .reset(reset), .level(back),  .rise_c(back_ev_c));

  menu_state_e       state_q, state_d;
  logic [SONG_W-1:0] cursor_q, cursor_d;
  logic [SONG_W-1:0] song_sel_q, song_sel_d;
  logic              game_reset_q, game_reset_d;
  logic              in_game_q, in_game_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= MENU;
      cursor_q     <= FIRST_SONG;
      song_sel_q   <= FIRST_SONG;
      game_reset_q <= 1'b0;
      in_game_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cursor_q     <= cursor_d;
      song_sel_q   <= song_sel_d;
      game_reset_q <= game_reset_d;
      in_game_q    <= in_game_d;
    end
  end

  // Next-state, cursor and selection logic
  always_comb begin
    state_d    = state_q;
    cursor_d   = cursor_q;
    song_sel_d = song_sel_q;

    case (state_q)
      MENU: begin
        // Enter wins over scrolling; the pre-move cursor is latched
        if (enter_ev_c) begin
          song_sel_d = cursor_q;
          state_d    = START;
        end else if (up_ev_c && !down_ev_c) begin
          if (cursor_q == FIRST_SONG) begin
`ifdef SONG_MENU_WRAP_EN
            cursor_d = LAST_SONG;
`else
            cursor_d = FIRST_SONG;
`endif
          end else begin
            cursor_d = cursor_q - SONG_W'(1);
          end
        end else if (down_ev_c && !up_ev_c) begin
          // >= also pulls any out-of-range value back into the legal range
          if (cursor_q >= LAST_SONG) begin
`ifdef SONG_MENU_WRAP_EN
            cursor_d = FIRST_SONG;
`else
            cursor_d = LAST_SONG;
`endif
          end else begin
            cursor_d = cursor_q + SONG_W'(1);
          end
        end
      end
      START: begin
        state_d = PLAY;
      end
      PLAY: begin
        // done has priority over an abort in the same cycle
        if (done) begin
          state_d = RESULT;
        end else if (back_ev_c) begin
          state_d = MENU;
        end
      end
      RESULT: begin
        if (enter_ev_c) begin
          state_d = MENU;
        end
      end
      default: begin
        state_d = MENU;
      end
    endcase

    game_reset_d = (state_d == START);
    in_game_d    = (state_d == PLAY);
  end

  assign menu_state = state_q;
  assign cursor     = cursor_q;
  assign song_sel   = song_sel_q;
  assign game_reset = game_reset_q;
  assign in_game    = in_game_q;

endmodule

// File: tb/tb_song_menu_fsm.sv
// Directed bench for song_menu_fsm: two instances (NUM_SONGS=4 and 5) share
// stimulus; expected values are queued before each clock and compared after it.
module tb_song_menu_fsm;

`ifdef SONG_MENU_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, up, down, enter, back, done;

  logic [1:0] ms4, ms5;
  logic [1:0] cur4, sel4;
  logic [2:0] cur5, sel5;
  logic       gr4, ig4, gr5, ig5;

  song_menu_fsm #(.NUM_SONGS(4)) dut4 (
    .clk(clk), .reset(reset), .up(up), .down(down), .enter(enter), .back(back),
    .done(done), .menu_state(ms4), .cursor(cur4), .song_sel(sel4),
    .game_reset(gr4), .in_game(ig4)
  );

  song_menu_fsm #(.NUM_SONGS(5)) dut5 (
    .clk(clk), .reset(reset), .up(up), .down(down), .enter(enter), .back(back),
    .done(done), .menu_state(ms5), .cursor(cur5), .song_sel(sel5),
    .game_reset(gr5), .in_game(ig5)
  );

  always #5 clk = ~clk;

  typedef enum int {S_STATE, S_CUR4, S_SEL4, S_GR, S_IG, S_CUR5, S_STATE5} sig_e;
  typedef struct {
    string      tag;
    sig_e       sig;
    logic [7:0] val;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   c4 = 0;
  int   c5 = 0;

  function automatic int cur_next(input int c, input int n, input bit u, input bit d);
    if (u && d) return c;
    if (u) return (c == 0) ? (WRAP ? n - 1 : 0) : c - 1;
    if (d) return (c == n - 1) ? (WRAP ? 0 : n - 1) : c + 1;
    return c;
  endfunction

  function automatic void push(input string tag, input sig_e sig, input int val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = 8'(val);
    q.push_back(e);
  endfunction

  function automatic logic [7:0] observe(input sig_e sig);
    case (sig)
      S_STATE:  return 8'(ms4);
      S_CUR4:   return 8'(cur4);
      S_SEL4:   return 8'(sel4);
      S_GR:     return 8'({gr5, gr4});
      S_IG:     return 8'({ig5, ig4});
      S_CUR5:   return 8'(cur5);
      S_STATE5: return 8'(ms5);
      default:  return 8'hxx;
    endcase
  endfunction

  // Queue the full output picture of both instances
  function automatic void push_all(input string tag, input int st, input int sel,
                                   input bit gr, input bit ig);
    push({tag, "_state"}, S_STATE, st);
    push({tag, "_state5"}, S_STATE5, st);
    push({tag, "_cur4"}, S_CUR4, c4);
    push({tag, "_cur5"}, S_CUR5, c5);
    push({tag, "_sel4"}, S_SEL4, sel);
    push({tag, "_gr"}, S_GR, gr ? 3 : 0);
    push({tag, "_ig"}, S_IG, ig ? 3 : 0);
  endfunction

  task automatic cyc();
    exp_t       e;
    logic [7:0] obs;
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e   = q.pop_front();
      obs = observe(e.sig);
      checks++;
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  // One button tap in MENU: press for a cycle, then release
  task automatic tap(input string tag, input bit u, input bit d);
    up   = u;
    down = d;
    c4 = cur_next(c4, 4, u, d);
    c5 = cur_next(c5, 5, u, d);
    push_all(tag, 0, -1, 1'b0, 1'b0);
    q.pop_back(); q.pop_back(); q.pop_back();
    cyc();
    up   = 1'b0;
    down = 1'b0;
    cyc();
  endtask

  initial begin
    int sel;
    reset = 1'b1; up = 1'b0; down = 1'b0; enter = 1'b0; back = 1'b0; done = 1'b0;
    cyc();
    push_all("reset", 0, 0, 1'b0, 1'b0);
    cyc();
    reset = 1'b0;

    // Two down presses then enter: START pulse, then PLAY
    tap("down1", 1'b0, 1'b1);
    tap("down2", 1'b0, 1'b1);
    enter = 1'b1;
    push_all("enter_start", 1, 2, 1'b1, 1'b0);
    cyc();
    push_all("enter_play", 2, 2, 1'b0, 1'b1);
    cyc();
    enter = 1'b0;
    up = 1'b1; down = 1'b1;
    push_all("play_ignore_scroll", 2, 2, 1'b0, 1'b1);
    cyc();
    up = 1'b0; down = 1'b0;

    // done and back together: done wins
    done = 1'b1; back = 1'b1;
    push_all("done_back", 3, 2, 1'b0, 1'b0);
    cyc();
    done = 1'b0; back = 1'b0;
    cyc();
    enter = 1'b1;
    push_all("result_exit", 0, 2, 1'b0, 1'b0);
    cyc();
    enter = 1'b0;
    cyc();

    // Held down for 20 cycles: exactly one step
    down = 1'b1;
    c4 = cur_next(c4, 4, 1'b0, 1'b1);
    c5 = cur_next(c5, 5, 1'b0, 1'b1);
    repeat (20) cyc();
    push("held_cur4", S_CUR4, c4);
    push("held_cur5", S_CUR5, c5);
    cyc();
    down = 1'b0;
    cyc();

    // Top boundary on the 4-entry instance, then walk back down to 0
    tap("down_top", 1'b0, 1'b1);
    repeat (4) tap("up_walk", 1'b1, 1'b0);
    tap("up_at0", 1'b1, 1'b0);
    tap("up_down_same", 1'b1, 1'b1);

    // Enter then back from PLAY: no extra game_reset
    sel = c4;
    enter = 1'b1;
    push_all("enter2_start", 1, sel, 1'b1, 1'b0);
    cyc();
    enter = 1'b0;
    push_all("enter2_play", 2, sel, 1'b0, 1'b1);
    cyc();
    back = 1'b1;
    push_all("back_menu", 0, sel, 1'b0, 1'b0);
    cyc();
    back = 1'b0;
    push_all("back_settle", 0, sel, 1'b0, 1'b0);
    cyc();

    // Reset mid-PLAY with enter held through reset release
    enter = 1'b1;
    cyc();
    enter = 1'b0;
    cyc();
    enter = 1'b1;
    reset = 1'b1;
    c4 = 0; c5 = 0;
    push_all("reset_midplay", 0, 0, 1'b0, 1'b0);
    cyc();
    reset = 1'b0;
    push_all("held_enter_masked", 0, 0, 1'b0, 1'b0);
    cyc();
    enter = 1'b0;
    cyc();

    // Seven down taps from 0 on both sizes
    for (int i = 0; i < 7; i++) tap($sformatf("down7_%0d", i), 1'b0, 1'b1);

    // Re-pressed enter is now a real event
    sel = c4;
    enter = 1'b1;
    push_all("enter_after_release", 1, sel, 1'b1, 1'b0);
    cyc();
    enter = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
